// File: rtl/ysyx_24100006_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24100006_rd_arbiter
//  Description : Two-master AXI-style read-channel arbiter. Master 0 is the
//                I$ and master 1 is the LSU. One downstream bus port is
//                shared between them. Simultaneous requests are resolved by
//                round-robin. The grant is held from AR acceptance through
//                the last R beat.
//  Option      : YSYX_24100006_RD_ARB_PERF_EN adds grant and conflict
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100006_rd_arbiter (
    input  logic        clk,
    input  logic        rst,
    // master 0 (I$)
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic        m0_rlast,
    // master 1 (LSU)
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic        m1_rlast,
    // shared bus
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic        s_rlast
`ifdef YSYX_24100006_RD_ARB_PERF_EN
    ,
    output logic [31:0] perf_m0_grants,
    output logic [31:0] perf_m1_grants,
    output logic [31:0] perf_conflict
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR0  = 3'd1,
        S_AR1  = 3'd2,
        S_R0   = 3'd3,
        S_R1   = 3'd4
    } state_t;

    localparam logic [2:0] c_ICACHE_SIZE = 3'b010;

    state_t r_state;
    logic   r_last_grant;   // 0: m0 was granted last, 1: m1 was granted last

    // Arbitration, address-phase acceptance and burst completion tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_arvalid && m1_arvalid) begin
                        r_state <= r_last_grant ? S_AR0 : S_AR1;
                    end else if (m0_arvalid) begin
                        r_state <= S_AR0;
                    end else if (m1_arvalid) begin
                        r_state <= S_AR1;
                    end
                end
                S_AR0: begin
                    if (!m0_arvalid) begin
                        r_state <= S_IDLE;
                    end else if (s_arready) begin
                        r_state      <= S_R0;
                        r_last_grant <= 1'b0;
                    end
                end
                S_AR1: begin
                    if (!m1_arvalid) begin
                        r_state <= S_IDLE;
                    end else if (s_arready) begin
                        r_state      <= S_R1;
                        r_last_grant <= 1'b1;
                    end
                end
                S_R0: begin
                    if (s_rvalid && m0_rready && s_rlast) begin
                        r_state <= S_IDLE;
                    end
                end
                S_R1: begin
                    if (s_rvalid && m1_rready && s_rlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Steer the granted master onto the bus; everything else stays at zero
    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = 32'd0;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = 32'd0;
        m0_rlast   = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = 32'd0;
        m1_rlast   = 1'b0;
        case (r_state)
            S_AR0: begin
                s_arvalid  = m0_arvalid;
                s_araddr   = m0_araddr;
                s_arlen    = m0_arlen;
                s_arsize   = c_ICACHE_SIZE;
                m0_arready = s_arready;
            end
            S_AR1: begin
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                m1_arready = s_arready;
            end
            S_R0: begin
                m0_rvalid = s_rvalid;
                m0_rdata  = s_rdata;
                m0_rlast  = s_rlast;
                s_rready  = m0_rready;
            end
            S_R1: begin
                m1_rvalid = s_rvalid;
                m1_rdata  = s_rdata;
                m1_rlast  = s_rlast;
                s_rready  = m1_rready;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

`ifdef YSYX_24100006_RD_ARB_PERF_EN
    logic w_m0_ar_hs;
    logic w_m1_ar_hs;
    logic w_conflict;

    assign w_m0_ar_hs = (r_state == S_AR0) && m0_arvalid && s_arready;
    assign w_m1_ar_hs = (r_state == S_AR1) && m1_arvalid && s_arready;
    // A master is stalled by the other one whenever it requests while the
    // other owns either the address or the data phase.
    assign w_conflict = (m0_arvalid && ((r_state == S_AR1) || (r_state == S_R1))) ||
                        (m1_arvalid && ((r_state == S_AR0) || (r_state == S_R0)));

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_m0_grants <= 32'd0;
            perf_m1_grants <= 32'd0;
            perf_conflict  <= 32'd0;
        end else begin
            if (w_m0_ar_hs) begin
                perf_m0_grants <= perf_m0_grants + 32'd1;
            end
            if (w_m1_ar_hs) begin
                perf_m1_grants <= perf_m1_grants + 32'd1;
            end
            if (w_conflict) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24100006_rd_arbiter
//  Description : Self-checking bench for the two-master read arbiter. A
//                simple bus slave returns beat data equal to address plus
//                beat index. An ownership model predicts every output on
//                every cycle. Directed scenarios add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100006_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr, m0_rdata;
    logic [7:0]  m0_arlen;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_rdata;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
`ifdef YSYX_24100006_RD_ARB_PERF_EN
    logic [31:0] perf_m0_grants, perf_m1_grants, perf_conflict;
`endif

    always #5 clk = ~clk;

    ysyx_24100006_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_rvalid(m1_rvalid),
        .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast)
`ifdef YSYX_24100006_RD_ARB_PERF_EN
        ,
        .perf_m0_grants(perf_m0_grants), .perf_m1_grants(perf_m1_grants),
        .perf_conflict(perf_conflict)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 0;

    function automatic logic [114:0] outs();
        return {s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
                m0_arready, m0_rvalid, m0_rdata, m0_rlast,
                m1_arready, m1_rvalid, m1_rdata, m1_rlast};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- ownership model ----------------
    // own: -1 nobody, 0 or 1 the master owning the bus; addr_ph: owner is
    // still in its address phase.
    int own = -1;
    bit addr_ph = 0;
    int last_g = 0;

    always @(posedge clk) begin : model
        if (rst) begin
            own = -1; addr_ph = 0; last_g = 0;
        end else if (own < 0) begin
            if (m0_arvalid && m1_arvalid) own = (last_g == 0) ? 1 : 0;
            else if (m0_arvalid)          own = 0;
            else if (m1_arvalid)          own = 1;
            addr_ph = 1;
        end else if (addr_ph) begin
            if (!((own == 0) ? m0_arvalid : m1_arvalid)) own = -1;
            else if (s_arready) begin addr_ph = 0; last_g = own; end
        end else if (s_rvalid && ((own == 0) ? m0_rready : m1_rready) && s_rlast) begin
            own = -1;
        end
    end

    logic        e_arv, e_rr, e0_ar, e0_rv, e0_rl, e1_ar, e1_rv, e1_rl;
    logic [31:0] e_addr, e0_rd, e1_rd;
    logic [7:0]  e_len;
    logic [2:0]  e_size;
    logic [114:0] e_vec, a_vec;

    always @(negedge clk) begin : compare
        if (started) begin
            e_arv = 0; e_addr = 0; e_len = 0; e_size = 0; e_rr = 0;
            e0_ar = 0; e0_rv = 0; e0_rd = 0; e0_rl = 0;
            e1_ar = 0; e1_rv = 0; e1_rd = 0; e1_rl = 0;
            if (own == 0 && addr_ph) begin
                e_arv = m0_arvalid; e_addr = m0_araddr; e_len = m0_arlen;
                e_size = 3'd2; e0_ar = s_arready;
            end
            if (own == 1 && addr_ph) begin
                e_arv = m1_arvalid; e_addr = m1_araddr; e_len = m1_arlen;
                e_size = m1_arsize; e1_ar = s_arready;
            end
            if (own == 0 && !addr_ph) begin
                e0_rv = s_rvalid; e0_rd = s_rdata; e0_rl = s_rlast; e_rr = m0_rready;
            end
            if (own == 1 && !addr_ph) begin
                e1_rv = s_rvalid; e1_rd = s_rdata; e1_rl = s_rlast; e_rr = m1_rready;
            end
            e_vec = {e_arv, e_addr, e_len, e_size, e_rr, e0_ar, e0_rv, e0_rd, e0_rl,
                     e1_ar, e1_rv, e1_rd, e1_rl};
            a_vec = outs();
            checks++;
            if (a_vec !== e_vec) begin
                failures++;
                $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, a_vec, e_vec);
            end
        end
    end

    // ---------------- bus slave ----------------
    bit          sl_busy = 0;
    int          sl_beat, sl_len;
    logic [31:0] sl_base, sl_last_addr;
    logic [2:0]  sl_last_size;
    int          gq[$];
    bit          s_har, s_hr, s_hl, s_rs, s_g1;
    logic [31:0] s_cap_addr;
    logic [7:0]  s_cap_len;
    logic [2:0]  s_cap_size;

    always @(posedge clk) begin : slave
        s_har = s_arvalid && s_arready; s_hr = s_rvalid && s_rready; s_hl = s_rlast;
        s_rs = rst; s_g1 = m1_arready;
        s_cap_addr = s_araddr; s_cap_len = s_arlen; s_cap_size = s_arsize;
        #1;
        if (s_rs) begin
            sl_busy = 0; s_arready = 1; s_rvalid = 0; s_rlast = 0; s_rdata = 0;
        end else if (s_har) begin
            gq.push_back(s_g1 ? 1 : 0);
            sl_last_addr = s_cap_addr; sl_last_size = s_cap_size;
            sl_busy = 1; sl_beat = 0; sl_len = int'(s_cap_len); sl_base = s_cap_addr;
            s_arready = 0; s_rvalid = 1; s_rdata = sl_base; s_rlast = (sl_len == 0);
        end else if (s_hr) begin
            if (s_hl) begin
                sl_busy = 0; s_arready = 1; s_rvalid = 0; s_rlast = 0; s_rdata = 0;
            end else begin
                sl_beat++;
                s_rdata = sl_base + 32'(sl_beat);
                s_rlast = (sl_beat == sl_len);
            end
        end
    end

    // ---------------- master-side collectors ----------------
    logic [31:0] q0[$], q1[$];
    int last0_idx, last0_cyc, hs1_cyc;
    bit m_h0, m_h1, m_d0, m_d1, m_l0, m_rs;
    logic [31:0] m_dat0, m_dat1;

    always @(posedge clk) begin : masters
        cyc++;
        m_h0 = m0_arvalid && m0_arready; m_h1 = m1_arvalid && m1_arready;
        m_d0 = m0_rvalid && m0_rready;   m_d1 = m1_rvalid && m1_rready;
        m_dat0 = m0_rdata; m_dat1 = m1_rdata; m_l0 = m0_rlast; m_rs = rst;
        if (m_d0) begin
            q0.push_back(m_dat0);
            if (m_l0) begin last0_idx = q0.size(); last0_cyc = cyc; end
        end
        if (m_d1) q1.push_back(m_dat1);
        if (m_h1) hs1_cyc = cyc;
        #1;
        if (m_rs) begin
            m0_arvalid = 0; m1_arvalid = 0;
        end else begin
            if (m_h0) m0_arvalid = 0;
            if (m_h1) m1_arvalid = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; m0_arvalid = 0; m1_arvalid = 0; m0_rready = 1; m1_rready = 1;
        @(posedge clk); #1;
        rst = 0;
        q0.delete(); q1.delete(); gq.delete();
    endtask

    task automatic req0(input logic [31:0] a, input logic [7:0] l);
        m0_araddr = a; m0_arlen = l; m0_arvalid = 1;
    endtask

    task automatic req1(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        m1_araddr = a; m1_arlen = l; m1_arsize = s; m1_arvalid = 1;
    endtask

    task automatic wait_q(input int who, input int n, input string nm);
        int k;
        k = 0;
        while (((who == 0) ? q0.size() : q1.size()) < n && k < 300) begin
            @(negedge clk); k++;
        end
        if (((who == 0) ? q0.size() : q1.size()) < n) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", nm,
                     (who == 0) ? q0.size() : q1.size(), n);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        rst = 1;
        m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 0; m1_rready = 1;
        s_arready = 1; s_rvalid = 0; s_rdata = 0; s_rlast = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        started = 1;
        chk("reset_outputs", 128'(outs()), 128'd0);
        @(posedge clk); #1;
        rst = 0;

        // single m0 burst of 4 beats
        do_reset();
        req0(32'h8000_0010, 8'd3);
        wait_q(0, 4, "m0_burst");
        chk("idle_after_last", 128'(outs()), 128'd0);
        chk("burst_araddr", 128'(sl_last_addr), 128'h8000_0010);
        chk("burst_arsize", 128'(sl_last_size), 128'd2);
        for (int i = 0; i < 4; i++) chk("burst_beat", 128'(q0[i]), 128'(32'h8000_0010 + i));
        chk("burst_rlast_beat", 128'(last0_idx), 128'd4);

        // round-robin on ties
        do_reset();
        req0(32'h0000_1000, 8'd3);
        req1(32'h0000_2000, 8'd1, 3'b001);
        wait_q(0, 4, "tie_first");
        chk("tie1_winner", 128'(gq[0]), 128'd1);
        chk("tie1_second", 128'(gq[1]), 128'd0);
        chk("tie1_m1_beat1", 128'(q1[1]), 128'h2001);
`ifdef YSYX_24100006_RD_ARB_PERF_EN
        chk("perf_m0_grants", 128'(perf_m0_grants), 128'd1);
        chk("perf_m1_grants", 128'(perf_m1_grants), 128'd1);
        chk("perf_conflict", 128'(perf_conflict), 128'd3);
`endif
        @(posedge clk); #1;
        req0(32'h0000_1100, 8'd0);
        req1(32'h0000_2200, 8'd0, 3'b001);
        wait_q(0, 5, "tie_second");
        chk("tie2_winner", 128'(gq[2]), 128'd1);

        // m1 request while m0 holds the bus
        do_reset();
        req0(32'h0000_3000, 8'd3);
        wait_q(0, 2, "pend_m0_half");
        @(posedge clk); #1;
        req1(32'h0000_4000, 8'd0, 3'b000);
        wait_q(1, 1, "pend_m1");
        chk("pend_m0_beats", 128'(q0.size()), 128'd4);
        chk("pend_hs_latency", 128'(hs1_cyc), 128'(last0_cyc + 2));
        chk("pend_m1_addr", 128'(sl_last_addr), 128'h4000);
        chk("pend_m1_size", 128'(sl_last_size), 128'd0);

        // m0 backpressure for 3 cycles mid-burst
        do_reset();
        req0(32'h0000_5000, 8'd3);
        wait_q(0, 1, "stall_first");
        @(posedge clk); #1;
        m0_rready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_s_rready", 128'(s_rready), 128'd0);
            @(posedge clk); #1;
        end
        m0_rready = 1;
        wait_q(0, 4, "stall_rest");
        chk("stall_count", 128'(q0.size()), 128'd4);
        for (int i = 0; i < 4; i++) chk("stall_order", 128'(q0[i]), 128'(32'h5000 + i));

        // reset in the middle of an m1 burst
        do_reset();
        req1(32'h0000_6000, 8'd3, 3'b010);
        k = 0;
        @(negedge clk);
        while (!m1_rvalid && k < 50) begin @(negedge clk); k++; end
        chk("midrst_saw_beat", 128'(m1_rvalid), 128'd1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_outputs", 128'(outs()), 128'd0);
        @(posedge clk); #1;
        rst = 0;
        q0.delete(); gq.delete();
        req0(32'h0000_7000, 8'd0);
        wait_q(0, 1, "after_rst");
        chk("after_rst_data", 128'(q0[0]), 128'h7000);
        chk("after_rst_grant", 128'(gq[0]), 128'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
